// File: rtl/fp_add_arbiter.sv
// fp_add_arbiter: round-robin sharing of one pipelined FP adder among NREQ
// requesters. The requester id rides a tag shift register alongside the adder,
// and results are collected in an output FIFO. A credit counter (occ) admits
// an operation only if a FIFO slot is guaranteed, because the adder cannot stall.
// Optional build macro FP_ADD_ARB_PERF_EN adds perf_issued / perf_blocked counters.
module fp_add_arbiter #(
    parameter int NREQ       = 4,
    parameter int PIPE_LAT   = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [32*NREQ-1:0]       req_a,
    input  logic [32*NREQ-1:0]       req_b,
    output logic [NREQ-1:0]          req_ready,
    output logic                     pipe_in_valid,
    output logic [31:0]              pipe_a,
    output logic [31:0]              pipe_b,
    input  logic [31:0]              pipe_result,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [$clog2(NREQ)-1:0]  rsp_id,
    output logic [31:0]              rsp_data
`ifdef FP_ADD_ARB_PERF_EN
    ,
    output logic [31:0]              perf_issued,
    output logic [31:0]              perf_blocked
`else
    // counters not built
`endif
);
    localparam int IDW  = $clog2(NREQ);
    localparam int OCCW = $clog2(FIFO_DEPTH + 1);
    localparam int PTRW = $clog2(FIFO_DEPTH);

    logic [NREQ-1:0][31:0]         a_lane, b_lane;
    logic [IDW-1:0]                last_grant, grant;
    logic                          grant_found, credit, accept, wr, pop;
    logic [OCCW-1:0]               occ, cnt;
    logic [PTRW-1:0]               wr_ptr, rd_ptr;
    logic [PIPE_LAT-1:0]           tag_vld;
    logic [PIPE_LAT-1:0][IDW-1:0]  tag_id;
    logic [IDW-1:0]                fifo_id   [FIFO_DEPTH];
    logic [31:0]                   fifo_data [FIFO_DEPTH];

    assign a_lane = req_a;
    assign b_lane = req_b;

    // Round-robin search starting just after the last grantee
    always_comb begin
        grant_found = 1'b0;
        grant       = '0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!grant_found && req_valid[IDW'((int'(last_grant) + k) % NREQ)]) begin
                grant_found = 1'b1;
                grant       = IDW'((int'(last_grant) + k) % NREQ);
            end
        end
    end

    // Credit uses registered occupancy only, so a same-cycle pop never frees a slot
    assign credit = (occ < OCCW'(FIFO_DEPTH));
    assign accept = grant_found && credit;

    // One-hot ready to the grantee when a FIFO slot is guaranteed
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NREQ; i++)
            req_ready[i] = accept && (grant == IDW'(i));
    end

    // Issue register feeding adder stage 1; operands hold when nothing issues
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_in_valid <= 1'b0;
            pipe_a        <= '0;
            pipe_b        <= '0;
            last_grant    <= IDW'(NREQ - 1);
        end else begin
            pipe_in_valid <= accept;
            if (accept) begin
                pipe_a     <= a_lane[grant];
                pipe_b     <= b_lane[grant];
                last_grant <= grant;
            end
        end
    end

    // Tag shift register tracking the adder stages; entry 0 pairs with stage 1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_vld <= '0;
            tag_id  <= '0;
        end else begin
            tag_vld[0] <= pipe_in_valid;
            tag_id[0]  <= last_grant;
            for (int k = 1; k < PIPE_LAT; k++) begin
                tag_vld[k] <= tag_vld[k-1];
                tag_id[k]  <= tag_id[k-1];
            end
        end
    end

    assign wr        = tag_vld[PIPE_LAT-1];
    assign rsp_valid = (cnt != '0);
    assign pop       = rsp_valid && rsp_ready;
    assign rsp_id    = fifo_id[rd_ptr];
    assign rsp_data  = fifo_data[rd_ptr];

    // Output FIFO; credit accounting keeps a write from ever meeting a full FIFO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int k = 0; k < FIFO_DEPTH; k++) begin
                fifo_id[k]   <= '0;
                fifo_data[k] <= '0;
            end
        end else begin
            if (wr) begin
                fifo_id[wr_ptr]   <= tag_id[PIPE_LAT-1];
                fifo_data[wr_ptr] <= pipe_result;
                wr_ptr <= (wr_ptr == PTRW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= (rd_ptr == PTRW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            case ({wr, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Occupancy: in-flight plus stored results, +1 on accept, -1 on pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ <= '0;
        end else begin
            case ({accept, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

`ifdef FP_ADD_ARB_PERF_EN
    // Free-running issue and blocked-cycle counters, wrapping at 2^32
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_issued  <= '0;
            perf_blocked <= '0;
        end else begin
            if (accept)
                perf_issued <= perf_issued + 32'd1;
            if ((|req_valid) && !accept)
                perf_blocked <= perf_blocked + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Bench for fp_add_arbiter: external adder model, request driver, and a
// spec-level model (round-robin pick, credit count, ordered response queue).
module tb_fp_add_arbiter;
    localparam int NREQ = 4, PIPE_LAT = 4, FIFO_DEPTH = 8;

    logic              clk = 1'b0, rst_n = 1'b0;
    logic [NREQ-1:0]   req_valid, req_ready;
    logic [32*NREQ-1:0] req_a, req_b;
    logic              pipe_in_valid;
    logic [31:0]       pipe_a, pipe_b, pipe_result;
    logic              rsp_valid, rsp_ready;
    logic [1:0]        rsp_id;
    logic [31:0]       rsp_data;
`ifdef FP_ADD_ARB_PERF_EN
    logic [31:0]       perf_issued, perf_blocked;
`endif

    always #5 clk = ~clk;

    fp_add_arbiter #(.NREQ(NREQ), .PIPE_LAT(PIPE_LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .pipe_in_valid(pipe_in_valid), .pipe_a(pipe_a), .pipe_b(pipe_b),
        .pipe_result(pipe_result), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data)
`ifdef FP_ADD_ARB_PERF_EN
        , .perf_issued(perf_issued), .perf_blocked(perf_blocked)
`endif
    );

    int checks = 0, failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Single-precision helpers, exact for the small integers used as operands
    function automatic logic [63:0] f2d(input logic [31:0] f);
        if (f[30:23] == 8'd0) return {f[31], 63'd0};
        return {f[31], 11'({3'b000, f[30:23]} + 11'd896), f[22:0], 29'd0};
    endfunction
    function automatic logic [31:0] d2f(input logic [63:0] d);
        if (d[62:52] == 11'd0) return {d[63], 31'd0};
        return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
    endfunction
    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        return d2f($realtobits($bitstoreal(f2d(a)) + $bitstoreal(f2d(b))));
    endfunction
    function automatic logic [31:0] i2f(input int n);
        int p = 0;
        if (n == 0) return 32'd0;
        for (int k = 0; k < 24; k++) if (n >= (1 << k)) p = k;
        return {1'b0, 8'(127 + p), 23'((n << (23 - p)) & 32'h7FFFFF)};
    endfunction

    // External 4-stage adder: stage 1 captures pipe_a/pipe_b every edge
    logic [31:0] add_stage [PIPE_LAT];
    always @(posedge clk) begin
        add_stage[0] <= fadd(pipe_a, pipe_b);
        for (int k = 1; k < PIPE_LAT; k++) add_stage[k] <= add_stage[k-1];
    end
    assign pipe_result = add_stage[PIPE_LAT-1];

    // Request driver: each requester presents its queue head until accepted
    logic [63:0] pend [NREQ][$];
    initial begin
        logic [NREQ-1:0] taken;
        req_valid = '0; req_a = '0; req_b = '0;
        forever begin
            @(negedge clk);
            taken = req_valid & req_ready;
            @(posedge clk); #1;
            for (int i = 0; i < NREQ; i++) begin
                if (taken[i] && pend[i].size() > 0) void'(pend[i].pop_front());
                req_valid[i] = (pend[i].size() > 0);
                if (req_valid[i]) begin
                    req_a[32*i +: 32] = pend[i][0][63:32];
                    req_b[32*i +: 32] = pend[i][0][31:0];
                end
            end
        end
    end

    // Spec-level model and the per-cycle compare process
    typedef struct { int id; logic [31:0] data; int rdy; } exp_t;
    exp_t exp_q[$];
    int now = 0, m_occ = 0, m_last = NREQ - 1, stall_cnt = 0, m_iss = 0, m_blk = 0;
    logic m_piv = 1'b0;
    logic [31:0] m_pa = '0, m_pb = '0;
    int acc_now[$], acc_id[$], pop_now[$];

    always @(negedge clk) begin
        logic [NREQ-1:0] er;
        int g;
        logic any, acc, pop, exp_v;
        now++;
        if (!rst_n) begin
            chk("rst_req_ready", req_ready, 0);
            chk("rst_pipe_in_valid", pipe_in_valid, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            exp_q.delete();
            m_occ = 0; m_last = NREQ - 1; m_piv = 0; m_pa = '0; m_pb = '0; m_iss = 0; m_blk = 0;
        end else begin
            chk("pipe_in_valid", pipe_in_valid, m_piv);
            chk("pipe_a", pipe_a, m_pa);
            chk("pipe_b", pipe_b, m_pb);
            chk("occ_bound", dut.occ <= FIFO_DEPTH, 1);
            any = |req_valid;
            g = -1;
            for (int k = 1; k <= NREQ; k++)
                if (g < 0 && req_valid[(m_last + k) % NREQ]) g = (m_last + k) % NREQ;
            acc = any && (m_occ < FIFO_DEPTH);
            er = '0;
            if (acc) er[g] = 1'b1;
            chk("req_ready", req_ready, er);
            exp_v = (exp_q.size() > 0) && (exp_q[0].rdy <= now);
            chk("rsp_valid", rsp_valid, exp_v);
            pop = exp_v && rsp_ready;
            if (exp_v) begin
                chk("rsp_id", rsp_id, exp_q[0].id);
                chk("rsp_data", rsp_data, exp_q[0].data);
            end
`ifdef FP_ADD_ARB_PERF_EN
            chk("perf_issued", perf_issued, m_iss);
            chk("perf_blocked", perf_blocked, m_blk);
`endif
            m_piv = acc;
            if (acc) begin
                m_pa = req_a[32*g +: 32];
                m_pb = req_b[32*g +: 32];
                exp_q.push_back('{g, fadd(m_pa, m_pb), now + PIPE_LAT + 2});
                m_last = g;
                acc_now.push_back(now);
                acc_id.push_back(g);
                m_iss++;
            end
            if (pop) begin
                void'(exp_q.pop_front());
                pop_now.push_back(now);
            end
            m_occ += int'(acc) - int'(pop);
            if (any && !acc) begin stall_cnt++; m_blk++; end
        end
    end

    task automatic tick();
        @(negedge clk); #1;
    endtask

    function automatic bit busy();
        bit b = (exp_q.size() != 0) || (req_valid != '0) || rsp_valid;
        for (int i = 0; i < NREQ; i++) if (pend[i].size() != 0) b = 1;
        return b;
    endfunction

    task automatic wait_idle();
        int n = 0;
        while (busy() && n < 300) begin tick(); n++; end
        checks++;
        if (busy()) begin
            failures++;
            $display("FAIL idle_timeout: still busy after %0d cycles, required idle", n);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        int n, ab, pb, sb;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        // Single op from requester 2: 1.0 + 2.0
        pend[2].push_back(64'h3F800000_40000000);
        n = 0;
        while (!(req_valid[2] && req_ready[2]) && n < 50) begin tick(); n++; end
        chk("single_ready", req_ready, 4'b0100);
        n = 0;
        do begin tick(); n++; end while (!rsp_valid && n < 50);
        chk("single_latency", n, 6);
        chk("single_id", rsp_id, 2);
        chk("single_data", rsp_data, 32'h40400000);
        wait_idle();

        // All requesters streaming, full-rate round robin
        do_reset();
        ab = acc_id.size(); pb = pop_now.size(); sb = stall_cnt;
        for (int j = 0; j < 8; j++)
            for (int i = 0; i < NREQ; i++)
                pend[i].push_back({i2f(10*i + j + 1), i2f(j + 1)});
        wait_idle();
        for (int k = 0; k < 8; k++) chk("rr_grant", acc_id[ab + k], k % 4);
        chk("rr_no_stall", stall_cnt - sb, 0);
        chk("rr_span", acc_now[ab + 31] - acc_now[ab], 31);
        chk("rr_pops", pop_now.size() - pb, 32);

        // Consumer stalled: credit caps issue at FIFO_DEPTH
        @(posedge clk); #2 rsp_ready = 1'b0;
        ab = acc_id.size(); pb = pop_now.size();
        for (int j = 0; j < 12; j++) pend[1].push_back({i2f(j + 3), i2f(2*j + 1)});
        repeat (20) tick();
        chk("fill_accepts", acc_id.size() - ab, 8);
        chk("fill_ready_low", req_ready, 0);
        @(posedge clk); #2 rsp_ready = 1'b1;
        wait_idle();
        chk("fill_total", acc_id.size() - ab, 12);
        chk("fill_pops", pop_now.size() - pb, 12);
        if (acc_id.size() - ab >= 9 && pop_now.size() > pb)
            chk("credit_return", acc_now[ab + 8] - pop_now[pb], 1);
        else chk("credit_return_present", 0, 1);

        // Reset with three ops in flight
        ab = acc_id.size();
        pend[0].push_back({i2f(5), i2f(6)});
        pend[1].push_back({i2f(7), i2f(8)});
        pend[3].push_back({i2f(9), i2f(4)});
        n = 0;
        while (acc_id.size() - ab < 3 && n < 50) begin tick(); n++; end
        chk("inflight_accepts", acc_id.size() - ab, 3);
        @(posedge clk); #2 rst_n = 1'b0;
        #1;
        chk("arst_req_ready", req_ready, 0);
        chk("arst_pipe_in_valid", pipe_in_valid, 0);
        chk("arst_pipe_a", pipe_a, 0);
        chk("arst_pipe_b", pipe_b, 0);
        chk("arst_rsp_valid", rsp_valid, 0);
        chk("arst_rsp_id", rsp_id, 0);
        chk("arst_rsp_data", rsp_data, 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        pb = pop_now.size();
        repeat (10) tick();
        chk("no_stale_rsp", pop_now.size() - pb, 0);
        pend[1].push_back({i2f(12), i2f(30)});
        wait_idle();
        chk("post_reset_rsp", pop_now.size() - pb, 1);

`ifdef FP_ADD_ARB_PERF_EN
        // 10 accepts with 3 credit-blocked cycles
        do_reset();
        @(posedge clk); #2 rsp_ready = 1'b0;
        sb = stall_cnt;
        for (int j = 0; j < 10; j++) pend[0].push_back({i2f(j + 1), i2f(1)});
        n = 0;
        while (stall_cnt - sb < 2 && n < 50) begin tick(); n++; end
        @(posedge clk); #2 rsp_ready = 1'b1;
        wait_idle();
        chk("perf_issued_10", perf_issued, 10);
        chk("perf_blocked_3", perf_blocked, 3);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
